clock_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave in cycles of the 100 MHz system clock. Its main target is the divided-clock signals in the design, such as the 10 kHz display-scan clock. The block sits beside those consumers as a self-check and debug monitor. Measurements are reported as registered counts with a one-cycle valid pulse, plus a lock flag, a tolerance flag against an expected period, and a loss-of-signal timeout.

---
 rtl/clock_period_meter.sv | 78 +++++++
 tb/tb_clock_period_meter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow async square wave in clk cycles
// Ports: clk, rst_n (async, active-low); meas_in (async input);
//   period, high_time (CNT_W-bit counts); valid (1-cycle update pulse);
//   locked; in_tol (|period-EXPECT| <= TOL while locked); timeout (1-cycle loss-of-signal pulse)
module clock_period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100000000,
  parameter int EXPECT      = 10000,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             in_tol,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, ARM, LOCKED} state_t;
  localparam int CW = CNT_W + 1;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);
  localparam logic [CW-1:0] LO = CW'(EXPECT);
  localparam logic [CW-1:0] HI = CW'(EXPECT + TOL);
  localparam logic [CW-1:0] TW = CW'(TOL);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, cnt_n, hcnt;
  logic s, s_d, rise, fall, expire, meas, tol_n;
  always_comb begin
    s = sync[SYNC_STAGES-1];
    rise = s & ~s_d;
    fall = ~s & s_d;
    expire = state != IDLE && cnt == TMAX && !rise;
    meas = state != IDLE && rise;
    // lower bound written as cnt+TOL >= EXPECT so it never underflows
    tol_n = ({1'b0, cnt} + TW >= LO) && ({1'b0, cnt} <= HI);
    state_n = rise ? (state == IDLE ? ARM : LOCKED) : expire ? IDLE : state;
    // cnt is cleared on expiry, so it never exceeds TMAX
    cnt_n = rise ? CNT_W'(1) : (state == IDLE || expire) ? '0 : cnt + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      s_d <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      hcnt <= '0;
      period <= '0;
      high_time <= '0;
      valid <= 1'b0;
      locked <= 1'b0;
      in_tol <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], meas_in};
      s_d <= s;
      state <= state_n;
      cnt <= cnt_n;
      valid <= meas;
      timeout <= expire;
      if (fall && state != IDLE) hcnt <= cnt;
      if (meas) begin
        period <= cnt;
        high_time <= hcnt;
        in_tol <= tol_n;
        locked <= 1'b1;
      end else if (expire) begin
        period <= '0;
        high_time <= '0;
        in_tol <= 1'b0;
        locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed vector bench for clock_period_meter
module tb_clock_period_meter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, meas_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic valid, locked, in_tol, timeout;
  int vectors = 0, miss = 0;
  int nvalid = 0, ntimeout = 0, overlap = 0, wide = 0, cyc = 0, v_cyc = 0, t_cyc = 0;
  int n0, nt0;
  logic prev_v = 1'b0, prev_t = 1'b0;
  typedef struct {int h; int l; int per; int hi; bit tol;} vec_t;
  vec_t tbl[9];

  clock_period_meter #(.CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(200), .EXPECT(100), .TOL(2)) dut (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .period(period), .high_time(high_time),
    .valid(valid), .locked(locked), .in_tol(in_tol), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (valid) begin nvalid++; v_cyc = cyc; end
    if (timeout) begin ntimeout++; t_cyc = cyc; end
    if (valid && timeout) overlap++;
    if ((valid && prev_v) || (timeout && prev_t)) wide++;
    prev_v = valid;
    prev_t = timeout;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // entered 5 cycles after a rise; next rise comes h+l cycles after the previous one
  task automatic seg(input int h, input int l);
    tick(h - 5);
    meas_in = 1'b0;
    tick(l);
    meas_in = 1'b1;
    tick(5);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_in_tol"}, in_tol, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic chk_meas(input string tag, input int nv, input int per, input int hi, input bit tol);
    chk({tag, "_nvalid"}, nvalid, nv);
    chk({tag, "_period"}, period, per);
    chk({tag, "_high"}, high_time, hi);
    chk({tag, "_in_tol"}, in_tol, tol);
    chk({tag, "_locked"}, locked, 1);
  endtask

  initial begin
    tbl[0] = '{50, 50, 100, 50, 1'b1};
    tbl[1] = '{50, 50, 100, 50, 1'b1};
    tbl[2] = '{25, 75, 100, 25, 1'b1};
    tbl[3] = '{50, 52, 102, 50, 1'b1};
    tbl[4] = '{50, 53, 103, 50, 1'b0};
    tbl[5] = '{47, 50, 97, 47, 1'b0};
    tbl[6] = '{50, 48, 98, 50, 1'b1};
    tbl[7] = '{100, 100, 200, 100, 1'b0};
    tbl[8] = '{50, 50, 100, 50, 1'b1};
    #2;
    chk_zero("reset");
    tick(3);
    rst_n = 1'b1;
    tick(10);
    meas_in = 1'b1;
    tick(5);
    chk("first_rise_nvalid", nvalid, 0);
    chk("first_rise_locked", locked, 0);
    for (int i = 0; i < 9; i++) begin
      n0 = nvalid;
      nt0 = ntimeout;
      seg(tbl[i].h, tbl[i].l);
      chk_meas($sformatf("vec%0d", i), n0 + 1, tbl[i].per, tbl[i].hi, tbl[i].tol);
      chk($sformatf("vec%0d_no_timeout", i), ntimeout, nt0);
    end
    n0 = nvalid;
    nt0 = ntimeout;
    meas_in = 1'b0;
    for (int i = 0; i < 400 && ntimeout == nt0; i++) tick(1);
    chk("loss_timeout_seen", ntimeout, nt0 + 1);
    chk("loss_timeout_delay", t_cyc - v_cyc, 200);
    chk("loss_locked", locked, 0);
    chk("loss_period", period, 0);
    chk("loss_high", high_time, 0);
    chk("loss_in_tol", in_tol, 0);
    tick(1);
    chk("loss_timeout_width", timeout, 0);
    tick(20);
    meas_in = 1'b1;
    tick(5);
    chk("restart_first_nvalid", nvalid, n0);
    seg(50, 50);
    chk_meas("restart", n0 + 1, 100, 50, 1'b1);
    tick(45);
    rst_n = 1'b0;
    meas_in = 1'b0;
    #1;
    chk_zero("midreset");
    tick(3);
    rst_n = 1'b1;
    tick(10);
    n0 = nvalid;
    meas_in = 1'b1;
    tick(5);
    chk("midreset_first_nvalid", nvalid, n0);
    chk("midreset_first_locked", locked, 0);
    seg(30, 70);
    chk_meas("midreset_relock", n0 + 1, 100, 30, 1'b1);
    chk("pulse_overlap", overlap, 0);
    chk("pulse_width", wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
